// File: rtl/gpio_in_filter_if.sv
// Pad-side and register-side signals of the GPIO input filter.
// The slave modport is the filter; the master modport drives pins and controls.
interface gpio_in_filter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pin_i;
  logic [WIDTH-1:0] din_o;
  logic [WIDTH-1:0] rise_en_i;
  logic [WIDTH-1:0] fall_en_i;
  logic [WIDTH-1:0] pend_clr_i;
  logic [WIDTH-1:0] pend_o;
  logic             irq_o;

  modport master (
    output pin_i,
    output rise_en_i,
    output fall_en_i,
    output pend_clr_i,
    input  din_o,
    input  pend_o,
    input  irq_o
  );

  modport slave (
    input  pin_i,
    input  rise_en_i,
    input  fall_en_i,
    input  pend_clr_i,
    output din_o,
    output pend_o,
    output irq_o
  );
endinterface

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop synchroniser, tick-based per-bit debounce,
// sticky rising/falling edge pending flags and a level interrupt.
module gpio_in_filter #(
  parameter int WIDTH        = 32,
  parameter int PRESCALE     = 16,
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = $clog2(DEBOUNCE_CNT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  gpio_in_filter_if.slave bus
);
  localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0]            r_stable;
  logic [WIDTH-1:0]            r_pend;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [PS_W-1:0]             r_ps;

  logic                        w_tick;
  logic [WIDTH-1:0]            w_stableNxt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cntNxt;
  logic [WIDTH-1:0]            w_rise;
  logic [WIDTH-1:0]            w_fall;

  // With PRESCALE=1 the counter is stuck at 0 and every cycle is a tick.
  assign w_tick = (r_ps == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps <= '0;
    end else if (w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + PS_W'(1);
    end
  end

  // Any cycle where the synchronised input agrees with the stable value
  // throws away the partial count, so only uninterrupted differences win.
  always_comb begin
    w_stableNxt = r_stable;
    w_cntNxt    = r_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_stable[i]) begin
        w_cntNxt[i] = '0;
      end else if (w_tick) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stableNxt[i] = r_sync2[i];
          w_cntNxt[i]    = '0;
        end else begin
          w_cntNxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise = w_stableNxt & ~r_stable & bus.rise_en_i;
  assign w_fall = ~w_stableNxt & r_stable & bus.fall_en_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
      r_pend   <= '0;
    end else begin
      r_sync1  <= bus.pin_i;
      r_sync2  <= r_sync1;
      r_stable <= w_stableNxt;
      r_cnt    <= w_cntNxt;
      r_pend   <= (r_pend & ~bus.pend_clr_i) | w_rise | w_fall;
    end
  end

  assign bus.din_o  = r_stable;
  assign bus.pend_o = r_pend;
  assign bus.irq_o  = |r_pend;
endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
Input conditioning stage for the GPIO peripheral. It sits between the SoC input pads and the gpio block's din port. Per bit, it synchronises the asynchronous pad inputs, debounces them with a shared prescaled tick, and presents the stable value on din_o. It also detects enabled rising/falling edges of the stable value, latches them as sticky pending flags, and raises a level interrupt line.

Parameters:
WIDTH, 32, number of GPIO input bits (gpio din is 32 bits)
PRESCALE, 16, clk cycles per debounce tick; legal range >=1
DEBOUNCE_CNT, 4, consecutive differing ticks required to accept a new level; legal range >=1
CNT_W, $clog2(DEBOUNCE_CNT+1), width of the per-bit debounce counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pin_i  input  WIDTH  raw asynchronous pad inputs
din_o  output  WIDTH  debounced stable value; drives gpio din
rise_en_i  input  WIDTH  per-bit enable for latching rising edges
fall_en_i  input  WIDTH  per-bit enable for latching falling edges
pend_clr_i  input  WIDTH  per-bit single-cycle clear of pending flags
pend_o  output  WIDTH  sticky edge-pending flags
irq_o  output  1  interrupt, equal to OR-reduction of pend_o

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high; all state changes on posedge clk.
- While rst=1 at a posedge, clear: sync1, sync2, stable (din_o), all debounce counters, prescaler, pend_o. irq_o=0.
- Reset asserted mid-debounce discards the partial count. No edge is flagged on reset exit, even if pins are high; pins high at reset exit go through a full debounce and are then flagged as rising edges if enabled.

Synchroniser:
- 2-flop chain per bit: sync1 <= pin_i; sync2 <= sync1. No other logic reads pin_i.

Prescaler:
- Counter runs 0..PRESCALE-1 and wraps to 0.
- tick=1 in the cycle the counter equals PRESCALE-1.
- PRESCALE=1 gives tick=1 every cycle.

Debounce, per bit i:
- If sync2[i]==stable[i]: cnt[i] <= 0 (glitch rejection, regardless of tick).
- Else if tick and cnt[i]==DEBOUNCE_CNT-1: stable[i] <= sync2[i]; cnt[i] <= 0.
- Else if tick: cnt[i] <= cnt[i]+1.
- Else: hold.
- Latency at PRESCALE=1, for a clean level change present before edge n: stable updates at edge n+1+DEBOUNCE_CNT (2 sync stages + DEBOUNCE_CNT ticks).
- Latency at PRESCALE>1 depends on tick phase: between (DEBOUNCE_CNT-1)*PRESCALE+3 and DEBOUNCE_CNT*PRESCALE+2 cycles.
- din_o = stable (registered, no combinational path from pin_i).

Edge and interrupt logic:
- rise[i] = (stable[i] goes 0->1 at this edge) & rise_en_i[i].
- fall[i] = (stable[i] goes 1->0 at this edge) & fall_en_i[i].
- pend[i] <= (pend[i] & ~pend_clr_i[i]) | rise[i] | fall[i]. Set wins over a simultaneous clear.
- pend_o updates at the same edge as din_o, so the new din_o value and the pending flag become visible together.
- Enable changes affect only future transitions; clearing an enable does not clear pend.
- irq_o = |pend_o (combinational from registers).
- All bits are independent; counters never overflow (bounded by DEBOUNCE_CNT-1).

Test Plan:
1. Reset/clean rise (PRESCALE=1, DEBOUNCE_CNT=4, rise_en=all 1s): assert rst 3 cycles; pin_i[0] 0->1 before edge 1 -> din_o[0]=1 and pend_o[0]=1 after edge 6, irq_o=1; other bits stay 0.
2. Glitch rejection (same params): pin_i[5] high for 3 cycles then low -> din_o[5] stays 0, pend_o=0, cnt returns to 0. A 6-cycle pulse is accepted: din_o[5] rises, then falls 6 cycles after the pulse ends.
3. Fall edge and enables: rise_en=0, fall_en[2]=1; pin_i[2] 0->1 then 1->0 (both held 10 cycles) -> no pend on rise; pend_o[2]=1 after the falling edge is accepted; irq_o=1.
4. Clear vs set: pend_o[3]=1; pulse pend_clr_i[3] one cycle -> pend_o[3]=0, irq_o=0. Then pulse pend_clr_i[3] in the exact cycle a new rise on bit 3 is accepted -> pend_o[3]=1.
5. Prescaler (PRESCALE=4, DEBOUNCE_CNT=3): pin_i[31] rises -> din_o[31] rises within 11..14 cycles. A 4-cycle glitch is never accepted.
6. Reset mid-operation: pin_i=32'hFFFF_FFFF, assert rst 1 cycle before acceptance -> din_o=0, pend_o=0. After release, a full debounce occurs, then din_o=32'hFFFF_FFFF with pend_o=32'hFFFF_FFFF (rise_en all 1s).
